// File: rtl/divider_pkg.sv
// divider_pkg: shared tag type, width defaults and round-robin helper for the divider scheduler
package divider_pkg;

    localparam int DEF_DATA_LEN = 32;
    localparam int ID_W         = 3;

    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
        logic            dbz;
    } t_div_tag;

    function automatic logic [ID_W-1:0] rr_next(input logic [ID_W-1:0] cur, input int n);
        return (int'(cur) == n - 1) ? '0 : cur + 1'b1;
    endfunction

endpackage

// File: rtl/divider_scheduler_rr_arbiter.sv
// rr_arbiter: one-hot round-robin grant whose pointer moves only when a grant is taken
module rr_arbiter
    import divider_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] grant
);

    localparam int W = 1 << ID_W;

    logic [ID_W-1:0] ptr;
    logic [ID_W-1:0] gidx;
    logic [ID_W-1:0] j;
    logic [W-1:0]    req_w;
    logic            hit;

    // scan from the pointer; the smallest offset holding a request wins
    always_comb begin
        req_w = W'(req);
        hit   = 1'b0;
        gidx  = ptr;
        j     = '0;
        for (int k = N - 1; k >= 0; k--) begin
            j = ID_W'((int'(ptr) + k) % N);
            if (req_w[j]) begin
                hit  = 1'b1;
                gidx = j;
            end
        end
        grant = hit ? N'(1) << gidx : '0;
    end

    // hand top priority to the requester after the one just served
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            ptr <= '0;
        else if (advance && hit)
            ptr <= rr_next(gidx, N);
    end

endmodule

// File: rtl/divider_scheduler.sv
// divider_scheduler: round-robin sharing of one fixed-latency pipelined divider among requesters
module divider_scheduler
    import divider_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int DATA_LEN    = DEF_DATA_LEN,
    parameter int DIV_LATENCY = 5
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_REQ-1:0]               req_valid,
    output logic [NUM_REQ-1:0]               req_ready,
    input  logic [NUM_REQ-1:0][DATA_LEN-1:0] req_a,
    input  logic [NUM_REQ-1:0][DATA_LEN-1:0] req_b,
    output logic [NUM_REQ-1:0]               rsp_valid,
    input  logic [NUM_REQ-1:0]               rsp_ready,
    output logic [NUM_REQ-1:0][DATA_LEN-1:0] rsp_result,
    output logic [NUM_REQ-1:0]               rsp_dbz,
    input  logic                             flush,
    output logic [DATA_LEN-1:0]              div_a,
    output logic [DATA_LEN-1:0]              div_b,
    output logic                             div_reset,
    input  logic [DATA_LEN-1:0]              div_result,
    output logic                             busy
);

    localparam int STAGES = DIV_LATENCY + 1;

    t_div_tag            tags [STAGES];
    t_div_tag            last;
    t_div_tag            new_tag;
    logic [NUM_REQ-1:0]  inflight;
    logic [NUM_REQ-1:0]  eligible;
    logic [NUM_REQ-1:0]  grant;
    logic                flush_q;
    logic                block;
    logic                issue;
    logic                any_tag;
    logic [ID_W-1:0]     gnt_id;
    logic [DATA_LEN-1:0] gnt_a;
    logic [DATA_LEN-1:0] gnt_b;

    // no issue while in reset, while flushing, or while the divider is being reset
    assign block     = !reset || flush || flush_q;
    assign eligible  = req_valid & ~inflight & ~rsp_valid & {NUM_REQ{!block}};
    assign issue     = |grant;
    assign req_ready = grant;
    assign last      = tags[STAGES-1];
    assign div_reset = !reset || flush_q;
    assign busy      = any_tag || |rsp_valid;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .clk     (clk),
        .reset   (reset),
        .req     (eligible),
        .advance (!block),
        .grant   (grant)
    );

    // which requesters own an operation anywhere in the tag pipe, including the capture stage
    always_comb begin
        inflight = '0;
        any_tag  = 1'b0;
        for (int k = 0; k < STAGES; k++) begin
            any_tag = any_tag || tags[k].valid;
            for (int i = 0; i < NUM_REQ; i++)
                if (tags[k].valid && tags[k].id == ID_W'(i))
                    inflight[i] = 1'b1;
        end
    end

    // operands and tag of the granted requester
    always_comb begin
        gnt_id = '0;
        gnt_a  = '0;
        gnt_b  = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (grant[i]) begin
                gnt_id = ID_W'(i);
                gnt_a  = req_a[i];
                gnt_b  = req_b[i];
            end
        new_tag.valid = issue;
        new_tag.id    = gnt_id;
        new_tag.dbz   = issue && gnt_b == '0;
    end

    // present issued operands for one cycle and shift the tag pipe; flush drops every tag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flush_q <= 1'b0;
            div_a   <= '0;
            div_b   <= '0;
            for (int k = 0; k < STAGES; k++)
                tags[k] <= '0;
        end else begin
            flush_q <= flush;
            div_a   <= issue ? gnt_a : '0;
            div_b   <= issue ? gnt_b : '0;
            tags[0] <= new_tag;
            for (int k = 1; k < STAGES; k++)
                tags[k] <= flush ? '0 : tags[k-1];
        end
    end

    // capture a returning quotient into its requester's slot and release it on handshake
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_valid  <= '0;
            rsp_dbz    <= '0;
            rsp_result <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (last.valid && !flush && last.id == ID_W'(i)) begin
                    rsp_valid[i]  <= 1'b1;
                    rsp_dbz[i]    <= last.dbz;
                    rsp_result[i] <= last.dbz ? '1 : div_result;
                end else if (rsp_valid[i] && rsp_ready[i]) begin
                    rsp_valid[i] <= 1'b0;
                end
            end
        end
    end

endmodule
